// File: rtl/if_stage_fifo.sv
// if_stage_fifo: multi-entry in-order instruction fetch buffer between pre-IF and ID.
// Up to DEPTH requests may be outstanding. Entries are allocated when inst_sram
// accepts the address and filled in order by data_ok. A flush (ws_ex/ws_eret)
// empties the buffer and counts the responses still owed so they can be dropped.
//
// Optional macro FS_BYPASS_EN: forward inst_sram_rdata straight to ID when it
// fills the head entry (zero-latency delivery).
//
// Ports:
//   clk, resetn                  clock, async active-low reset
//   pfs_to_fs_valid/_pc          request accepted by inst_sram this cycle and its PC
//   fs_allowin                   stage can accept a request this cycle
//   ds_allowin                   ID accepts the head entry
//   fs_to_ds_valid/_bus          head entry to ID: {ex, bd, badvaddr, inst, pc}
//   ds_is_branch                 becomes the bd field
//   inst_sram_data_ok/_rdata     in-order read response
//   inst_sram_data_waiting       responses are still owed to this stage
//   fs_full                      all DEPTH entries allocated
//   ws_ex, ws_eret               flush requests
module if_stage_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pfs_to_fs_valid,
  input  logic [31:0] pfs_to_fs_pc,
  output logic        fs_allowin,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [97:0] fs_to_ds_bus,
  input  logic        ds_is_branch,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        inst_sram_data_waiting,
  output logic        fs_full,
  input  logic        ws_ex,
  input  logic        ws_eret
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr, wr_ptr, fill_ptr;
  logic [CNT_W-1:0] count;     // allocated entries
  logic [CNT_W-1:0] owed;      // allocated entries still waiting for data
  logic [CNT_W-1:0] discard;   // stale responses to drop after a flush
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [DEPTH-1:0] adel_q;

  logic             flush;
  logic             accept;
  logic             push;
  logic             pop;
  logic             fill;
  logic             drop;
  logic             bypass;
  logic             head_filled;
  logic [31:0]      head_inst;
  logic [CNT_W:0]   discard_flush;

  assign flush       = ws_ex | ws_eret;
  assign fs_allowin  = (count < CNT_W'(DEPTH)) && (discard == '0);
  assign fs_full     = (count == CNT_W'(DEPTH));
  assign head_filled = filled_q[rd_ptr];

  // A request accepted by inst_sram still owes a response even in a flush cycle.
  assign accept = pfs_to_fs_valid && fs_allowin;
  assign push   = accept && !flush;
  assign fill   = inst_sram_data_ok && (discard == '0) && !flush;
  assign drop   = inst_sram_data_ok && (discard != '0) && !flush;

`ifdef FS_BYPASS_EN
  // Head is the oldest unfilled entry and its data is arriving right now.
  assign bypass = (count != '0) && !head_filled && (fill_ptr == rd_ptr) && fill;
`else
  assign bypass = 1'b0;
`endif

  assign fs_to_ds_valid = (count != '0) && (head_filled || bypass) && !flush;
  assign pop            = fs_to_ds_valid && ds_allowin;
  assign head_inst      = bypass ? inst_sram_rdata : inst_q[rd_ptr];

  assign fs_to_ds_bus = {adel_q[rd_ptr], ds_is_branch, pc_q[rd_ptr], head_inst, pc_q[rd_ptr]};

  assign inst_sram_data_waiting = (owed != '0) || (discard != '0);

  // Responses still owed after a flush; one extra bit absorbs the intermediate sum.
  assign discard_flush = (CNT_W+1)'(discard) + (CNT_W+1)'(owed)
                       + (CNT_W+1)'(accept) - (CNT_W+1)'(inst_sram_data_ok);

  // Pointers, counters and entry storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fill_ptr <= '0;
      count    <= '0;
      owed     <= '0;
      discard  <= '0;
      filled_q <= '0;
      adel_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fill_ptr <= '0;
      count    <= '0;
      owed     <= '0;
      filled_q <= '0;
      discard  <= CNT_W'(discard_flush);
    end else begin
      if (push) begin
        pc_q[wr_ptr]     <= pfs_to_fs_pc;
        adel_q[wr_ptr]   <= (pfs_to_fs_pc[1:0] != 2'b00);
        filled_q[wr_ptr] <= 1'b0;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (fill) begin
        // A forwarded-and-consumed head never needs to be stored.
        if (!(bypass && pop)) begin
          inst_q[fill_ptr]   <= inst_sram_rdata;
          filled_q[fill_ptr] <= 1'b1;
        end
        fill_ptr <= fill_ptr + PTR_W'(1);
      end
      if (drop) begin
        discard <= discard - CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      owed  <= owed + CNT_W'(push) - CNT_W'(fill);
    end
  end

endmodule

// File: tb/tb_if_stage_fifo.sv
// Bench for if_stage_fifo: directed scenarios plus randomized traffic checked
// against a queue-based model of the fetch buffer.
module tb_if_stage_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
`ifdef FS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        pfs_to_fs_valid;
  logic [31:0] pfs_to_fs_pc;
  logic        fs_allowin;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [97:0] fs_to_ds_bus;
  logic        ds_is_branch;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        inst_sram_data_waiting;
  logic        fs_full;
  logic        ws_ex;
  logic        ws_eret;

  int checks = 0;
  int errors = 0;

  if_stage_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .resetn(resetn),
    .pfs_to_fs_valid(pfs_to_fs_valid), .pfs_to_fs_pc(pfs_to_fs_pc),
    .fs_allowin(fs_allowin), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .ds_is_branch(ds_is_branch),
    .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .inst_sram_data_waiting(inst_sram_data_waiting), .fs_full(fs_full),
    .ws_ex(ws_ex), .ws_eret(ws_eret)
  );

  always #5 clk = ~clk;

  wire [31:0] bus_pc   = fs_to_ds_bus[31:0];
  wire [31:0] bus_inst = fs_to_ds_bus[63:32];
  wire [31:0] bus_bad  = fs_to_ds_bus[95:64];
  wire        bus_ex   = fs_to_ds_bus[97];

  task automatic drive(input logic pv, input logic [31:0] pc, input logic dok,
                       input logic [31:0] rd, input logic dsa);
    pfs_to_fs_valid   = pv;
    pfs_to_fs_pc      = pc;
    inst_sram_data_ok = dok;
    inst_sram_rdata   = rd;
    ds_allowin        = dsa;
    ds_is_branch      = 1'b0;
    ws_ex             = 1'b0;
    ws_eret           = 1'b0;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    resetn = 1'b0;
    nxt();
    nxt();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (fs_allowin !== 1'b1) begin errors++; $display("FAIL rst_allowin: got %b want 1", fs_allowin); end
    checks++; if (fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", fs_to_ds_valid); end
    checks++; if (fs_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", fs_full); end
    checks++; if (inst_sram_data_waiting !== 1'b0) begin errors++; $display("FAIL rst_waiting: got %b want 0", inst_sram_data_waiting); end
    checks++; if (fs_to_ds_bus !== 98'h0) begin errors++; $display("FAIL rst_bus: got %h want 0", fs_to_ds_bus); end
    nxt();
  endtask

  // Two back-to-back fetches delivered in order.
  task automatic test_basic();
    drive(1'b1, 32'hBFC00000, 1'b0, 32'h0, 1'b1); #1;
    checks++; if (fs_allowin !== 1'b1) begin errors++; $display("FAIL basic_allowin: got %b want 1", fs_allowin); end
    nxt();
    drive(1'b1, 32'hBFC00004, 1'b0, 32'h0, 1'b1); nxt();
    drive(1'b0, 32'h0, 1'b1, 32'h24080001, 1'b1); #1;
    checks++; if (fs_to_ds_valid !== BYP) begin errors++; $display("FAIL basic_valid_c0: got %b want %b", fs_to_ds_valid, BYP); end
    if (fs_to_ds_valid) begin
      checks++; if (bus_inst !== 32'h24080001 || bus_pc !== 32'hBFC00000) begin errors++; $display("FAIL basic_bus_c0: got pc %h inst %h want BFC00000 24080001", bus_pc, bus_inst); end
    end
    nxt();
    drive(1'b0, 32'h0, 1'b1, 32'h24080002, 1'b1); #1;
    checks++; if (fs_to_ds_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_c1: got %b want 1", fs_to_ds_valid); end
    checks++;
    if (bus_pc !== (BYP ? 32'hBFC00004 : 32'hBFC00000) || bus_inst !== (BYP ? 32'h24080002 : 32'h24080001) || bus_ex !== 1'b0) begin
      errors++; $display("FAIL basic_bus_c1: got pc %h inst %h ex %b", bus_pc, bus_inst, bus_ex);
    end
    nxt();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); #1;
    checks++; if (fs_to_ds_valid !== !BYP) begin errors++; $display("FAIL basic_valid_c2: got %b want %b", fs_to_ds_valid, !BYP); end
    if (fs_to_ds_valid) begin
      checks++; if (bus_pc !== 32'hBFC00004 || bus_inst !== 32'h24080002) begin errors++; $display("FAIL basic_bus_c2: got pc %h inst %h want BFC00004 24080002", bus_pc, bus_inst); end
    end
    nxt();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); #1;
    checks++; if (fs_to_ds_valid !== 1'b0 || inst_sram_data_waiting !== 1'b0) begin errors++; $display("FAIL basic_idle: got valid %b waiting %b want 0 0", fs_to_ds_valid, inst_sram_data_waiting); end
    nxt();
  endtask

  // Full buffer: a coincident pop does not admit a push in the same cycle.
  task automatic test_full();
    logic [31:0] exp_pc [4];
    logic [31:0] exp_in [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin drive(1'b1, 32'hBFC00100 + 32'(4*i), 1'b0, 32'h0, 1'b0); nxt(); end
    for (int i = 0; i < 4; i++) begin drive(1'b0, 32'h0, 1'b1, 32'hA0000000 + 32'(i), 1'b0); nxt(); end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
    checks++; if (fs_full !== 1'b1 || fs_allowin !== 1'b0) begin errors++; $display("FAIL full_flags: got full %b allowin %b want 1 0", fs_full, fs_allowin); end
    nxt();
    drive(1'b1, 32'hBFC00200, 1'b0, 32'h0, 1'b1); #1;
    checks++; if (fs_allowin !== 1'b0 || fs_to_ds_valid !== 1'b1 || bus_pc !== 32'hBFC00100) begin errors++; $display("FAIL full_pop: got allowin %b valid %b pc %h want 0 1 BFC00100", fs_allowin, fs_to_ds_valid, bus_pc); end
    nxt();
    drive(1'b1, 32'hBFC00200, 1'b0, 32'h0, 1'b0); #1;
    checks++; if (fs_full !== 1'b0 || fs_allowin !== 1'b1 || bus_pc !== 32'hBFC00104) begin errors++; $display("FAIL full_after_pop: got full %b allowin %b pc %h want 0 1 BFC00104", fs_full, fs_allowin, bus_pc); end
    nxt();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
    checks++; if (fs_full !== 1'b1 || inst_sram_data_waiting !== 1'b1) begin errors++; $display("FAIL full_refill: got full %b waiting %b want 1 1", fs_full, inst_sram_data_waiting); end
    nxt();
    exp_pc = '{32'hBFC00104, 32'hBFC00108, 32'hBFC0010C, 32'hBFC00200};
    exp_in = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'h00000055};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, (i == 0), 32'h00000055, 1'b1); #1;
      checks++; if (fs_to_ds_valid !== 1'b1 || bus_pc !== exp_pc[i] || bus_inst !== exp_in[i]) begin
        errors++; $display("FAIL full_drain%0d: got valid %b pc %h inst %h want 1 %h %h", i, fs_to_ds_valid, bus_pc, bus_inst, exp_pc[i], exp_in[i]);
      end
      nxt();
    end
  endtask

  // Flush with three unfilled entries; their responses are dropped.
  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 32'hBFC00010 + 32'(4*i), 1'b0, 32'h0, 1'b1); nxt(); end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); ws_ex = 1'b1; nxt();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1); #1;
      checks++; if (fs_allowin !== 1'b0 || fs_to_ds_valid !== 1'b0 || inst_sram_data_waiting !== 1'b1 || fs_full !== 1'b0) begin
        errors++; $display("FAIL flush_drop%0d: got allowin %b valid %b waiting %b full %b want 0 0 1 0", k, fs_allowin, fs_to_ds_valid, inst_sram_data_waiting, fs_full);
      end
      nxt();
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); #1;
    checks++; if (fs_allowin !== 1'b1 || inst_sram_data_waiting !== 1'b0 || fs_to_ds_valid !== 1'b0) begin
      errors++; $display("FAIL flush_done: got allowin %b waiting %b valid %b want 1 0 0", fs_allowin, inst_sram_data_waiting, fs_to_ds_valid);
    end
    nxt();
  endtask

  // Flush coinciding with data_ok and an accepted request.
  task automatic test_flush_collide();
    do_reset();
    for (int i = 0; i < 2; i++) begin drive(1'b1, 32'hBFC000C0 + 32'(4*i), 1'b0, 32'h0, 1'b1); nxt(); end
    drive(1'b1, 32'hBFC00300, 1'b1, 32'hDEADBEEF, 1'b1); ws_eret = 1'b1; #1;
    checks++; if (fs_allowin !== 1'b1 || fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL coll_flush: got allowin %b valid %b want 1 0", fs_allowin, fs_to_ds_valid); end
    nxt();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0); #1;
      checks++; if (fs_allowin !== 1'b0 || fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL coll_drop%0d: got allowin %b valid %b want 0 0", k, fs_allowin, fs_to_ds_valid); end
      nxt();
    end
    drive(1'b1, 32'hBFC00380, 1'b0, 32'h0, 1'b0); #1;
    checks++; if (fs_allowin !== 1'b1) begin errors++; $display("FAIL coll_allowin: got %b want 1", fs_allowin); end
    nxt();
    drive(1'b0, 32'h0, 1'b1, 32'h11112222, 1'b0); #1;
    checks++; if (fs_to_ds_valid !== BYP) begin errors++; $display("FAIL coll_valid_c0: got %b want %b", fs_to_ds_valid, BYP); end
    nxt();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
    checks++; if (fs_to_ds_valid !== 1'b1 || bus_pc !== 32'hBFC00380 || bus_inst !== 32'h11112222 || bus_ex !== 1'b0) begin
      errors++; $display("FAIL coll_deliver: got valid %b pc %h inst %h ex %b want 1 BFC00380 11112222 0", fs_to_ds_valid, bus_pc, bus_inst, bus_ex);
    end
    nxt();
  endtask

  // Misaligned PC raises ex with badvaddr = pc.
  task automatic test_adel();
    do_reset();
    drive(1'b1, 32'hBFC00002, 1'b0, 32'h0, 1'b0); nxt();
    drive(1'b0, 32'h0, 1'b1, 32'h24080003, 1'b0); nxt();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
    checks++; if (fs_to_ds_valid !== 1'b1 || bus_ex !== 1'b1 || bus_bad !== 32'hBFC00002 || bus_pc !== 32'hBFC00002 || bus_inst !== 32'h24080003) begin
      errors++; $display("FAIL adel: got valid %b ex %b bad %h pc %h inst %h want 1 1 BFC00002 BFC00002 24080003", fs_to_ds_valid, bus_ex, bus_bad, bus_pc, bus_inst);
    end
    nxt();
  endtask

  // Asynchronous reset mid-cycle, with live entries and with pending discards.
  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin drive(1'b1, 32'hBFC00040 + 32'(4*i), 1'b0, 32'h0, 1'b0); nxt(); end
    drive(1'b0, 32'h0, 1'b1, 32'h0000AAAA, 1'b0); nxt();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
    checks++; if (fs_to_ds_valid !== 1'b1 || inst_sram_data_waiting !== 1'b1) begin errors++; $display("FAIL arst_pre: got valid %b waiting %b want 1 1", fs_to_ds_valid, inst_sram_data_waiting); end
    #1 resetn = 1'b0; #1;
    checks++; if (fs_to_ds_valid !== 1'b0 || fs_allowin !== 1'b1 || inst_sram_data_waiting !== 1'b0 || fs_full !== 1'b0 || fs_to_ds_bus !== 98'h0) begin
      errors++; $display("FAIL arst_entries: got valid %b allowin %b waiting %b full %b bus %h", fs_to_ds_valid, fs_allowin, inst_sram_data_waiting, fs_full, fs_to_ds_bus);
    end
    nxt(); resetn = 1'b1;
    drive(1'b1, 32'hBFC00050, 1'b0, 32'h0, 1'b0); nxt();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); ws_ex = 1'b1; nxt();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
    checks++; if (fs_allowin !== 1'b0) begin errors++; $display("FAIL arst_disc_pre: got allowin %b want 0", fs_allowin); end
    #1 resetn = 1'b0; #1;
    checks++; if (fs_allowin !== 1'b1 || inst_sram_data_waiting !== 1'b0) begin errors++; $display("FAIL arst_discard: got allowin %b waiting %b want 1 0", fs_allowin, inst_sram_data_waiting); end
    nxt(); resetn = 1'b1;
    test_basic();
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          filled;
  } ent_t;

  // Random traffic against a queue model: entries in fetch order, plus a count of stale responses.
  task automatic test_random();
    ent_t        q[$];
    int          disc;
    int          owed;
    logic        pv, dok, dsa, br, ex, er, flush, e_allow, e_valid, e_wait;
    logic [31:0] pc, rd, e_inst;
    logic [97:0] e_bus;
    do_reset();
    nxt();
    disc = 0;
    for (int n = 0; n < 3000; n++) begin
      owed = 0;
      foreach (q[i]) if (!q[i].filled) owed++;
      pv  = 1'($urandom_range(0, 2) != 0);
      pc  = $urandom;
      if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
      dok = ((owed + disc) > 0) && ($urandom_range(0, 1) == 1);
      rd  = $urandom;
      dsa = 1'($urandom_range(0, 2) != 0);
      br  = 1'($urandom_range(0, 1));
      ex  = ($urandom_range(0, 29) == 0);
      er  = ($urandom_range(0, 49) == 0);
      assert (!(dok && owed == 0 && disc == 0));
      drive(pv, pc, dok, rd, dsa);
      ds_is_branch = br; ws_ex = ex; ws_eret = er;
      #1;
      flush   = ex | er;
      e_allow = (q.size() < DEPTH) && (disc == 0);
      e_wait  = (owed > 0) || (disc > 0);
      e_valid = (q.size() > 0) && q[0].filled && !flush;
      e_inst  = (q.size() > 0) ? q[0].inst : 32'h0;
      if (BYP && q.size() > 0 && !q[0].filled && dok && disc == 0 && !flush) begin
        e_valid = 1'b1; e_inst = rd;
      end
      checks++; if (fs_allowin !== e_allow) begin errors++; $display("FAIL rnd_allowin @%0d: got %b want %b", n, fs_allowin, e_allow); end
      checks++; if (fs_full !== (q.size() == DEPTH)) begin errors++; $display("FAIL rnd_full @%0d: got %b want %b", n, fs_full, q.size() == DEPTH); end
      checks++; if (inst_sram_data_waiting !== e_wait) begin errors++; $display("FAIL rnd_waiting @%0d: got %b want %b", n, inst_sram_data_waiting, e_wait); end
      checks++; if (fs_to_ds_valid !== e_valid) begin errors++; $display("FAIL rnd_valid @%0d: got %b want %b", n, fs_to_ds_valid, e_valid); end
      if (e_valid) begin
        e_bus = {(q[0].pc[1:0] != 2'b00), br, q[0].pc, e_inst, q[0].pc};
        checks++; if (fs_to_ds_bus !== e_bus) begin errors++; $display("FAIL rnd_bus @%0d: got %h want %h", n, fs_to_ds_bus, e_bus); end
      end
      if (flush) begin
        disc = disc + owed + int'(pv && e_allow) - int'(dok);
        q.delete();
      end else begin
        if (dok) begin
          if (disc > 0) disc--;
          else foreach (q[i]) if (!q[i].filled) begin q[i].filled = 1'b1; q[i].inst = rd; break; end
        end
        if (e_valid && dsa) void'(q.pop_front());
        if (pv && e_allow) q.push_back('{pc: pc, inst: 32'h0, filled: 1'b0});
      end
      nxt();
    end
  endtask

  initial begin
    resetn = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    test_reset();
    test_basic();
    test_full();
    test_flush();
    test_flush_collide();
    test_adel();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
